// File: rtl/obstacle_manager_if.sv
// Control inputs and obstacle-field outputs of obstacle_manager.
// The master side is the game top level; the slave side is the manager.
interface obstacle_manager_if #(
    parameter int unsigned NUM_OBS = 2,
    parameter int unsigned POS_W   = 8
);
    logic                       i_tick;
    logic                       i_run;
    logic                       i_restart;
    logic                       i_speed_up;
    logic [7:0]                 i_rng;
    logic [NUM_OBS*POS_W-1:0]   o_obs_pos;
    logic [NUM_OBS*3-1:0]       o_obs_type;
    logic [NUM_OBS-1:0]         o_obs_active;
    logic [2:0]                 o_speed;
    logic                       o_spawn_pulse;

    modport master (
        output i_tick, i_run, i_restart, i_speed_up, i_rng,
        input  o_obs_pos, o_obs_type, o_obs_active, o_speed, o_spawn_pulse
    );

    modport slave (
        input  i_tick, i_run, i_restart, i_speed_up, i_rng,
        output o_obs_pos, o_obs_type, o_obs_active, o_speed, o_spawn_pulse
    );
endinterface

// File: rtl/obstacle_manager.sv
// Multi-channel obstacle spawner/scroller: spawns at SPAWN_POS with random type and gap,
// scrolls left by the current speed on each running game tick, and retires off-screen.
module obstacle_manager #(
    parameter int unsigned NUM_OBS   = 2,
    parameter int unsigned CONV      = 2,
    parameter int unsigned SPAWN_POS = 159,
    parameter int unsigned MIN_GAP   = 40,
    parameter int unsigned NUM_TYPES = 5,
    parameter int unsigned SPEED_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    obstacle_manager_if.slave  bus
);
    localparam int unsigned POS_W = 10 - CONV;

    typedef enum logic {StIdle, StActive} state_e;

    state_e           r_state     [NUM_OBS];
    state_e           w_state_nxt [NUM_OBS];
    logic [POS_W-1:0] r_pos       [NUM_OBS];
    logic [POS_W-1:0] w_pos_nxt   [NUM_OBS];
    logic [2:0]       r_type      [NUM_OBS];
    logic [2:0]       w_type_nxt  [NUM_OBS];
    logic [2:0]       r_speed, w_speed_nxt;
    logic [7:0]       r_gap, w_gap_nxt;
    logic             r_spawn, w_spawn_nxt;

    logic               w_event;
    logic               w_spawn;
    logic               w_any_idle;
    logic [NUM_OBS-1:0] w_spawn_sel;
    logic [NUM_OBS-1:0] w_retire;
    logic [POS_W-1:0]   w_speed_ext;
    logic [2:0]         w_rng_lo;
    logic [2:0]         w_rng_type;
    logic               w_unused_rng;

    assign w_event      = bus.i_tick & bus.i_run;
    assign w_speed_ext  = POS_W'(r_speed);
    assign w_rng_lo     = bus.i_rng[2:0];
    assign w_rng_type   = (32'(w_rng_lo) >= NUM_TYPES) ? w_rng_lo - 3'(NUM_TYPES) : w_rng_lo;
    assign w_unused_rng = ^bus.i_rng[7:6];

    // Eligibility uses the pre-event state, so a channel retiring now cannot respawn now.
    always_comb begin
        w_any_idle  = 1'b0;
        w_spawn_sel = '0;
        w_retire    = '0;
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            if (r_state[i] == StIdle && !w_any_idle) begin
                w_spawn_sel[i] = 1'b1;
                w_any_idle     = 1'b1;
            end
            w_retire[i] = (r_state[i] == StActive) && (r_pos[i] < w_speed_ext);
        end
    end

    assign w_spawn = w_event & (r_gap == 8'd0) & w_any_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_OBS); i++) begin
                r_state[i] <= StIdle;
            end
        end else begin
            for (int i = 0; i < int'(NUM_OBS); i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            w_state_nxt[i] = r_state[i];
            if (bus.i_restart) begin
                w_state_nxt[i] = StIdle;
            end else if (w_event) begin
                unique case (r_state[i])
                    StIdle:   if (w_spawn && w_spawn_sel[i]) w_state_nxt[i] = StActive;
                    StActive: if (w_retire[i]) w_state_nxt[i] = StIdle;
                    default:  w_state_nxt[i] = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            w_pos_nxt[i]  = r_pos[i];
            w_type_nxt[i] = r_type[i];
            if (bus.i_restart) begin
                w_pos_nxt[i]  = '1;
                w_type_nxt[i] = 3'd0;
            end else if (w_event) begin
                if (r_state[i] == StActive) begin
                    w_pos_nxt[i] = w_retire[i] ? '1 : r_pos[i] - w_speed_ext;
                end else if (w_spawn && w_spawn_sel[i]) begin
                    w_pos_nxt[i]  = POS_W'(SPAWN_POS);
                    w_type_nxt[i] = w_rng_type;
                end
            end
        end

        w_gap_nxt = r_gap;
        if (bus.i_restart) begin
            w_gap_nxt = 8'(MIN_GAP);
        end else if (w_spawn) begin
            w_gap_nxt = 8'(MIN_GAP) + {2'b00, bus.i_rng[5:0]};
        end else if (w_event && r_gap != 8'd0) begin
            w_gap_nxt = r_gap - 8'd1;
        end

        // A speed_up alongside an event only takes effect on the following event.
        w_speed_nxt = r_speed;
        if (bus.i_restart) begin
            w_speed_nxt = 3'd1;
        end else if (bus.i_speed_up && r_speed < 3'(SPEED_MAX)) begin
            w_speed_nxt = r_speed + 3'd1;
        end

        w_spawn_nxt = w_spawn & ~bus.i_restart;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_OBS); i++) begin
                r_pos[i]  <= '1;
                r_type[i] <= 3'd0;
            end
            r_speed <= 3'd1;
            r_gap   <= 8'(MIN_GAP);
            r_spawn <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_OBS); i++) begin
                r_pos[i]  <= w_pos_nxt[i];
                r_type[i] <= w_type_nxt[i];
            end
            r_speed <= w_speed_nxt;
            r_gap   <= w_gap_nxt;
            r_spawn <= w_spawn_nxt;
        end
    end

    always_comb begin
        bus.o_obs_pos    = '0;
        bus.o_obs_type   = '0;
        bus.o_obs_active = '0;
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            bus.o_obs_pos[i*POS_W +: POS_W] = r_pos[i];
            bus.o_obs_type[i*3 +: 3]        = r_type[i];
            bus.o_obs_active[i]             = (r_state[i] == StActive);
        end
        bus.o_speed       = r_speed;
        bus.o_spawn_pulse = r_spawn;
    end
endmodule

// File: tb/tb_obstacle_manager.sv
// Self-checking bench for obstacle_manager: scoreboard against a behavioural model every
// cycle, a vector table for type/gap decoding, and directed multi-cycle scenarios.
module tb_obstacle_manager;
    localparam int NUM_OBS   = 2;
    localparam int CONV      = 2;
    localparam int POS_W     = 10 - CONV;
    localparam int SPAWN_POS = 159;
    localparam int MIN_GAP   = 40;
    localparam int NUM_TYPES = 5;
    localparam int SPEED_MAX = 4;

    typedef logic [27:0] snap_t;
    typedef struct {
        logic [7:0] rng;
        int         exp_type;
        int         exp_gap;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obstacle_manager_if #(.NUM_OBS(NUM_OBS), .POS_W(POS_W)) bus ();

    obstacle_manager #(
        .NUM_OBS   (NUM_OBS),
        .CONV      (CONV),
        .SPAWN_POS (SPAWN_POS),
        .MIN_GAP   (MIN_GAP),
        .NUM_TYPES (NUM_TYPES),
        .SPEED_MAX (SPEED_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_cmp  = 0;
    int    n_fail = 0;
    snap_t sb_q[$];

    int m_pos  [NUM_OBS];
    int m_type [NUM_OBS];
    bit m_act  [NUM_OBS];
    int m_speed;
    int m_gap;
    bit m_spawn;

    task automatic model_reset();
        for (int i = 0; i < NUM_OBS; i++) begin
            m_pos[i]  = 255;
            m_type[i] = 0;
            m_act[i]  = 1'b0;
        end
        m_speed = 1;
        m_gap   = MIN_GAP;
        m_spawn = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit r, input bit rs, input bit su,
                              input logic [7:0] rn);
        int free;
        int typ;
        if (rs) begin
            model_reset();
            return;
        end
        m_spawn = 1'b0;
        if (t && r) begin
            free = -1;
            for (int i = 0; i < NUM_OBS; i++) if (!m_act[i] && free < 0) free = i;
            for (int i = 0; i < NUM_OBS; i++) begin
                if (m_act[i]) begin
                    if (m_pos[i] < m_speed) begin
                        m_act[i] = 1'b0;
                        m_pos[i] = 255;
                    end else begin
                        m_pos[i] = m_pos[i] - m_speed;
                    end
                end
            end
            if (m_gap == 0 && free >= 0) begin
                typ = int'(rn) % 8;
                if (typ >= NUM_TYPES) typ = typ - NUM_TYPES;
                m_act[free]  = 1'b1;
                m_pos[free]  = SPAWN_POS;
                m_type[free] = typ;
                m_gap        = MIN_GAP + (int'(rn) % 64);
                m_spawn      = 1'b1;
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end
        end
        if (su && m_speed < SPEED_MAX) m_speed = m_speed + 1;
    endtask

    function automatic snap_t model_snap();
        return {8'(m_pos[1]), 8'(m_pos[0]), 3'(m_type[1]), 3'(m_type[0]),
                m_act[1], m_act[0], 3'(m_speed), m_spawn};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input bit t, input bit r, input bit rs, input bit su,
                         input logic [7:0] rn);
        snap_t got;
        snap_t exp;
        bus.i_tick     = t;
        bus.i_run      = r;
        bus.i_restart  = rs;
        bus.i_speed_up = su;
        bus.i_rng      = rn;
        model_step(t, r, rs, su, rn);
        sb_q.push_back(model_snap());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        got = {bus.o_obs_pos, bus.o_obs_type, bus.o_obs_active, bus.o_speed,
               bus.o_spawn_pulse};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got %h expected %h", $time, got, exp);
        end
    endtask

    // Idle cycle then a running tick; outputs afterwards reflect that event.
    task automatic do_tick(input logic [7:0] rn, input bit su);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, rn);
        cycle(1'b1, 1'b1, 1'b0, su, rn);
    endtask

    vec_t vecs[5];

    initial begin
        int cnt;
        bit got_spawn;

        vecs[0] = '{rng: 8'h06, exp_type: 1, exp_gap: 46};
        vecs[1] = '{rng: 8'h3F, exp_type: 2, exp_gap: 103};
        vecs[2] = '{rng: 8'h05, exp_type: 0, exp_gap: 45};
        vecs[3] = '{rng: 8'h04, exp_type: 4, exp_gap: 44};
        vecs[4] = '{rng: 8'hC7, exp_type: 2, exp_gap: 47};

        bus.i_tick = 1'b0; bus.i_run = 1'b0; bus.i_restart = 1'b0;
        bus.i_speed_up = 1'b0; bus.i_rng = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pos", int'(bus.o_obs_pos), 16'hFFFF);
        check("reset_type", int'(bus.o_obs_type), 0);
        check("reset_active", int'(bus.o_obs_active), 0);
        check("reset_speed", int'(bus.o_speed), 1);
        check("reset_spawn", int'(bus.o_spawn_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Gap countdown, first spawn, scroll to 0, retire, spawn blocked while full.
        for (int ev = 1; ev <= 202; ev++) begin
            do_tick(8'h00, 1'b0);
            if (ev == 40) check("t40_no_spawn", int'(bus.o_spawn_pulse), 0);
            if (ev == 41) begin
                check("t41_spawn", int'(bus.o_spawn_pulse), 1);
                check("t41_pos0", int'(bus.o_obs_pos[7:0]), SPAWN_POS);
                check("t41_type0", int'(bus.o_obs_type[2:0]), 0);
                check("t41_active", int'(bus.o_obs_active), 1);
            end
            if (ev == 81) check("gap40_hold", int'(bus.o_spawn_pulse), 0);
            if (ev == 82) check("ch1_spawn", int'(bus.o_obs_active), 3);
            if (ev == 200) check("ch0_pos0", int'(bus.o_obs_pos[7:0]), 0);
            if (ev == 201) begin
                check("ch0_retire_act", int'(bus.o_obs_active), 2);
                check("ch0_retire_pos", int'(bus.o_obs_pos[7:0]), 255);
                check("no_spawn_on_retire", int'(bus.o_spawn_pulse), 0);
            end
            if (ev == 202) begin
                check("respawn_ch0", int'(bus.o_spawn_pulse), 1);
                check("respawn_pos0", int'(bus.o_obs_pos[7:0]), SPAWN_POS);
                check("respawn_active", int'(bus.o_obs_active), 3);
            end
        end

        // Type folding and gap reload, gap measured as ticks to the next spawn.
        foreach (vecs[v]) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            for (int k = 0; k < MIN_GAP; k++) do_tick(8'h00, 1'b0);
            do_tick(vecs[v].rng, 1'b0);
            check($sformatf("vec%0d_spawn", v), int'(bus.o_spawn_pulse), 1);
            check($sformatf("vec%0d_type", v), int'(bus.o_obs_type[2:0]), vecs[v].exp_type);
            cnt = 0;
            got_spawn = 1'b0;
            while (!got_spawn && cnt < 300) begin
                do_tick(8'h00, 1'b0);
                cnt++;
                if (bus.o_spawn_pulse) got_spawn = 1'b1;
            end
            check($sformatf("vec%0d_gap", v), cnt, vecs[v].exp_gap + 1);
        end

        // Speed saturation, then speed_up coinciding with a tick.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
            if (k == 0) check("speed_2", int'(bus.o_speed), 2);
        end
        check("speed_sat", int'(bus.o_speed), SPEED_MAX);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k <= MIN_GAP; k++) do_tick(8'h00, 1'b0);
        check("sp_spawn_pos", int'(bus.o_obs_pos[7:0]), SPAWN_POS);
        do_tick(8'h00, 1'b1);
        check("sp_old_speed", int'(bus.o_obs_pos[7:0]), 157);
        do_tick(8'h00, 1'b0);
        check("sp_new_speed", int'(bus.o_obs_pos[7:0]), 154);

        // Frozen while run=0, then restart with tick.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        end
        check("frozen_pos", int'(bus.o_obs_pos[7:0]), 154);
        check("frozen_active", int'(bus.o_obs_active), 1);
        check("frozen_speed", int'(bus.o_speed), 3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        check("rs_pos", int'(bus.o_obs_pos), 16'hFFFF);
        check("rs_active", int'(bus.o_obs_active), 0);
        check("rs_speed", int'(bus.o_speed), 1);
        check("rs_spawn", int'(bus.o_spawn_pulse), 0);
        for (int k = 0; k < MIN_GAP; k++) do_tick(8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h03);
        check("rs_blocks_spawn", int'(bus.o_spawn_pulse), 0);
        check("rs_blocks_active", int'(bus.o_obs_active), 0);
        check("rs_blocks_speed", int'(bus.o_speed), 1);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 3) == 0, ($urandom % 8) != 0, ($urandom % 600) == 0,
                  ($urandom % 50) == 0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
